positadd_arbiter: RTL

- Shares one 4-stage posit adder (NBITS=32, ES=2; inputs in1/in2/start, outputs result/inf/zero/done) between NREQ requesters.
- Round-robin arbitration; issues one operation per cycle maximum.
- Tracks in-flight tags in order and returns each result to its requester through a per-requester response FIFO.
- Uses credit-based issue so results never overflow, because the adder has no backpressure.

---
 rtl/positadd_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/positadd_arbiter.sv
// Round-robin, credit-based sharing of one pipelined posit adder between NREQ requesters.
// Per-requester grant counters are built only when POSITADD_ARB_STATS_EN is defined.
module positadd_arbiter #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 4,
  parameter int NBITS      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_in1,
  input  logic [NREQ*NBITS-1:0] req_in2,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*NBITS-1:0] resp_result,
  output logic [NREQ-1:0]       resp_inf,
  output logic [NREQ-1:0]       resp_zero,
  output logic [NBITS-1:0]      add_in1,
  output logic [NBITS-1:0]      add_in2,
  output logic                  add_start,
  input  logic [NBITS-1:0]      add_result,
  input  logic                  add_inf,
  input  logic                  add_zero,
  input  logic                  add_done,
  output logic                  err_orphan,
  output logic [NREQ*16-1:0]    stat_grants
);
  localparam int TW  = $clog2(NREQ);
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int RPW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int TD  = LATENCY + 1;
  localparam int TPW = (TD > 1) ? $clog2(TD) : 1;
  localparam int TCW = $clog2(TD + 1);
  localparam int FCW = $clog2(LATENCY + 2);

  typedef enum logic {FLUSH, RUN} state_t;
  state_t state, state_next;
  logic [FCW-1:0] flush_cnt, flush_cnt_next;
  logic run;

  logic [TW-1:0]   rr_ptr, grant_idx;
  logic            grant_any;
  logic [NREQ-1:0] eligible, resp_push;

  logic [TW-1:0]  tag_mem [TD];
  logic [TPW-1:0] tag_wr, tag_rd;
  logic [TCW-1:0] tag_cnt;
  logic           tag_pop;
  logic [TW-1:0]  done_tag;

  assign run = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FLUSH;
      flush_cnt <= FCW'(LATENCY + 1);
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // The adder cannot be reset, so wait out anything still in its pipe.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      FLUSH: begin
        if (flush_cnt <= FCW'(1)) begin
          state_next     = RUN;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    logic [TW:0] sum;
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    if (run) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, rr_ptr} + (TW+1)'(k);
        if (sum >= (TW+1)'(NREQ)) sum = sum - (TW+1)'(NREQ);
        if (!grant_any && eligible[sum[TW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = sum[TW-1:0];
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign tag_pop  = run && add_done && (tag_cnt != '0);
  assign done_tag = tag_mem[tag_rd];

  always_ff @(posedge clk) begin
    if (grant_any) tag_mem[tag_wr] <= grant_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
    end else begin
      if (grant_any) tag_wr <= (tag_wr == TPW'(TD - 1)) ? '0 : tag_wr + 1'b1;
      if (tag_pop)   tag_rd <= (tag_rd == TPW'(TD - 1)) ? '0 : tag_rd + 1'b1;
      tag_cnt <= tag_cnt + TCW'(grant_any) - TCW'(tag_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_start  <= 1'b0;
      add_in1    <= '0;
      add_in2    <= '0;
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      add_start <= grant_any;
      add_in1   <= grant_any ? req_in1[grant_idx*NBITS +: NBITS] : '0;
      add_in2   <= grant_any ? req_in2[grant_idx*NBITS +: NBITS] : '0;
      if (grant_any) rr_ptr <= (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      if (run && add_done && (tag_cnt == '0)) err_orphan <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [CW-1:0]    occ, inflight;
    logic [RPW-1:0]   wr_ptr, rd_ptr;
    logic [NBITS+1:0] mem [RESP_DEPTH];
    logic             pop;

    assign resp_push[gi]  = tag_pop && (done_tag == TW'(gi));
    assign resp_valid[gi] = (occ != '0);
    assign pop            = resp_valid[gi] && resp_ready[gi];
    // A credit is held from grant until the consumer pops the response.
    assign eligible[gi]   = req_valid[gi] &&
                            (({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(RESP_DEPTH));

    assign resp_result[gi*NBITS +: NBITS] = mem[rd_ptr][NBITS+1:2];
    assign resp_inf[gi]                   = mem[rd_ptr][1];
    assign resp_zero[gi]                  = mem[rd_ptr][0];

    always_ff @(posedge clk) begin
      if (resp_push[gi]) mem[wr_ptr] <= {add_result, add_inf, add_zero};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        occ      <= '0;
        inflight <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        occ      <= occ + CW'(resp_push[gi]) - CW'(pop);
        inflight <= inflight + CW'(req_ready[gi]) - CW'(resp_push[gi]);
        if (resp_push[gi]) wr_ptr <= (wr_ptr == RPW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)           rd_ptr <= (rd_ptr == RPW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

`ifdef POSITADD_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (req_ready[gi] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stat_grants[gi*16 +: 16] = cnt;
  end
`else
  assign stat_grants = '0;
`endif

endmodule
